// File: rtl/dram_rr_arbiter_if.sv
// Bus bundle between the core array, the arbiter and the shared data RAM.
//   core_memREAD/core_memWRITE : per-core request bits, held until ack
//   core_addr/core_wdata       : per-core address / write data, flattened lanes
//   core_rdata/core_ack        : broadcast read data and one-hot completion strobe
//   mem_addr/mem_wdata/mem_re/mem_we/mem_rdata : single-port RAM side
// master = arbiter view, slave = environment (cores + RAM) view.
interface dram_rr_arbiter_if #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8,
  parameter int NCORE  = 4
);
  logic [NCORE-1:0]        core_memREAD;
  logic [NCORE-1:0]        core_memWRITE;
  logic [NCORE*AWIDTH-1:0] core_addr;
  logic [NCORE*WIDTH-1:0]  core_wdata;
  logic [WIDTH-1:0]        core_rdata;
  logic [NCORE-1:0]        core_ack;
  logic [AWIDTH-1:0]       mem_addr;
  logic [WIDTH-1:0]        mem_wdata;
  logic                    mem_re;
  logic                    mem_we;
  logic [WIDTH-1:0]        mem_rdata;

  modport master (
    input  core_memREAD, core_memWRITE, core_addr, core_wdata, mem_rdata,
    output core_rdata, core_ack, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport slave (
    output core_memREAD, core_memWRITE, core_addr, core_wdata, mem_rdata,
    input  core_rdata, core_ack, mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/dram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM among NCORE cores.
// One RAM access per grant: IDLE picks a core, ISSUE strobes the RAM for one
// cycle, WAIT covers the RD_LAT read latency, ACK pulses core_ack[grant].
// Ports:
//   Clk, Rst : clock (rising edge), asynchronous active-high reset
//   bus      : dram_rr_arbiter_if.master (core request side + RAM side)
//   busy     : high whenever the FSM is not in IDLE
module dram_rr_arbiter #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8,
  parameter int NCORE  = 4,
  parameter int RD_LAT = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  dram_rr_arbiter_if.master    bus,
  output logic                 busy
);
  localparam int GW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;

  logic [NCORE-1:0]             req;
  logic [NCORE-1:0][AWIDTH-1:0] lane_addr;
  logic [NCORE-1:0][WIDTH-1:0]  lane_wdata;
  logic [GW-1:0]                pick;
  logic                         found;
  int                           idx;

  assign req        = bus.core_memREAD | bus.core_memWRITE;
  assign lane_addr  = bus.core_addr;
  assign lane_wdata = bus.core_wdata;

  // First requester searching upward from last_grant+1, wrapping at NCORE.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NCORE; k++) begin
      idx = (int'(last_q) + k) % NCORE;
      if (!found && req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      last_q  <= GW'(NCORE - 1);
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        addr_d  = lane_addr[pick];
        wdata_d = lane_wdata[pick];
        // Write wins when both bits are set; the read is dropped.
        wr_d    = bus.core_memWRITE[pick];
        state_d = ISSUE;
      end
      ISSUE: begin
        if (wr_q) state_d = ACK;
        else begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bus.mem_rdata;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    bus.core_ack = '0;
    if (state_q == ACK) bus.core_ack[grant_q] = 1'b1;
    bus.core_rdata = rdata_q;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = wdata_q;
    bus.mem_re     = (state_q == ISSUE) && !wr_q;
    bus.mem_we     = (state_q == ISSUE) && wr_q;
    busy           = (state_q != IDLE);
  end
endmodule

// File: tb/tb_dram_rr_arbiter.sv
module tb_dram_rr_arbiter;
  localparam int WIDTH = 8, AWIDTH = 8, NCORE = 4, RD_LAT = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic busy;
  always #5 Clk = ~Clk;

  dram_rr_arbiter_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .NCORE(NCORE)) bus ();

  dram_rr_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .NCORE(NCORE), .RD_LAT(RD_LAT)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .bus  (bus),
    .busy (busy)
  );

  // RAM model: preloaded on reset, RD_LAT-cycle read pipe.
  logic [WIDTH-1:0] ram   [256];
  logic [WIDTH-1:0] rpipe [RD_LAT];
  assign bus.mem_rdata = rpipe[RD_LAT-1];

  always @(posedge Clk) begin
    if (Rst) begin
      for (int a = 0; a < 256; a++) ram[a] <= '0;
      ram[8'h00] <= 8'h11;
      ram[8'h01] <= 8'h22;
      ram[8'h02] <= 8'h33;
      ram[8'h03] <= 8'h44;
      ram[8'h05] <= 8'hAA;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_re) rpipe[0] <= ram[bus.mem_addr];
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int               core;
    logic             rd;
    logic             wr;
    logic [7:0]       addr;
    logic [7:0]       wdata;
    logic [3:0]       exp_ack;
    logic [7:0]       exp_rdata;
    int               exp_lat;
    logic             exp_we;
  } vec_t;

  // Background lanes get junk so a wrong lane select shows up.
  task automatic drive_core(input int c, input logic rd, input logic wr,
                            input logic [7:0] a, input logic [7:0] d);
    bus.core_memREAD[c]        = rd;
    bus.core_memWRITE[c]       = wr;
    bus.core_addr[c*AWIDTH +: AWIDTH] = a;
    bus.core_wdata[c*WIDTH +: WIDTH]  = d;
  endtask

  task automatic clear_reqs();
    bus.core_memREAD  = '0;
    bus.core_memWRITE = '0;
    bus.core_addr     = 32'hE7D6C5B4;
    bus.core_wdata    = 32'h9A8B7C6D;
  endtask

  // Step cycles until an ack or the bound; gather what the RAM side saw.
  task automatic wait_ack(input int bound, output logic [3:0] ack, output int lat,
                          output int nre, output int nwe, output logic [7:0] saddr,
                          output logic [7:0] swd, output logic busy_ok, output int nboth);
    ack = '0; lat = 0; nre = 0; nwe = 0; saddr = '0; swd = '0; busy_ok = 1'b1; nboth = 0;
    while (ack == '0 && lat < bound) begin
      @(posedge Clk); #1;
      lat++;
      if (bus.mem_re) nre++;
      if (bus.mem_we) begin nwe++; swd = bus.mem_wdata; end
      if (bus.mem_re && bus.mem_we) nboth++;
      if (bus.mem_re || bus.mem_we) saddr = bus.mem_addr;
      if (!busy) busy_ok = 1'b0;
      ack = bus.core_ack;
    end
  endtask

  vec_t vecs [5];

  initial begin
    logic [3:0] ack;
    int lat, nre, nwe, nboth;
    logic [7:0] saddr, swd;
    logic busy_ok;
    logic [3:0] exp_seq [5];
    logic [7:0] exp_dat [5];

    vecs[0] = '{0, 1'b1, 1'b0, 8'h05, 8'h00, 4'b0001, 8'hAA, 4, 1'b0};
    vecs[1] = '{2, 1'b0, 1'b1, 8'h10, 8'h3C, 4'b0100, 8'hAA, 2, 1'b1};
    vecs[2] = '{3, 1'b1, 1'b0, 8'h10, 8'h00, 4'b1000, 8'h3C, 4, 1'b0};
    vecs[3] = '{1, 1'b1, 1'b1, 8'h20, 8'h5A, 4'b0010, 8'h3C, 2, 1'b1};
    vecs[4] = '{0, 1'b1, 1'b0, 8'h20, 8'h00, 4'b0001, 8'h5A, 4, 1'b0};

    clear_reqs();
    #2;
    chk("rst_ack",   32'(bus.core_ack), 0);
    chk("rst_re_we", 32'({bus.mem_re, bus.mem_we}), 0);
    chk("rst_addr",  32'(bus.mem_addr), 0);
    chk("rst_rdata", 32'(bus.core_rdata), 0);
    chk("rst_busy",  32'(busy), 0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    // Single transactions from the table.
    foreach (vecs[i]) begin
      @(posedge Clk); #1;
      clear_reqs();
      drive_core(vecs[i].core, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_ack(12, ack, lat, nre, nwe, saddr, swd, busy_ok, nboth);
      clear_reqs();
      chk($sformatf("v%0d_ack", i),   32'(ack), 32'(vecs[i].exp_ack));
      chk($sformatf("v%0d_lat", i),   lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_rdata", i), 32'(bus.core_rdata), 32'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_nwe", i),   nwe, vecs[i].exp_we ? 1 : 0);
      chk($sformatf("v%0d_nre", i),   nre, vecs[i].exp_we ? 0 : 1);
      chk($sformatf("v%0d_both", i),  nboth, 0);
      chk($sformatf("v%0d_addr", i),  32'(saddr), 32'(vecs[i].addr));
      if (vecs[i].exp_we) chk($sformatf("v%0d_wdata", i), 32'(swd), 32'(vecs[i].wdata));
      chk($sformatf("v%0d_busy", i),  32'(busy_ok), 1);
      @(posedge Clk); #1;
      chk($sformatf("v%0d_ack_1cyc", i), 32'(bus.core_ack), 0);
      chk($sformatf("v%0d_idle", i),     32'(busy), 0);
    end
    chk("ram_20", 32'(ram[8'h20]), 32'h5A);

    // Reset during WAIT of a core 2 read: no ack, everything back to zero.
    @(posedge Clk); #1;
    drive_core(2, 1'b1, 1'b0, 8'h02, 8'h00);
    @(posedge Clk); #1;
    chk("mw_issue_re", 32'(bus.mem_re), 1);
    @(posedge Clk); #1;
    clear_reqs();
    Rst = 1'b1;
    #1;
    chk("mw_ack",   32'(bus.core_ack), 0);
    chk("mw_re_we", 32'({bus.mem_re, bus.mem_we}), 0);
    chk("mw_addr",  32'(bus.mem_addr), 0);
    chk("mw_rdata", 32'(bus.core_rdata), 0);
    chk("mw_busy",  32'(busy), 0);
    @(negedge Clk);
    Rst = 1'b0;
    wait_ack(6, ack, lat, nre, nwe, saddr, swd, busy_ok, nboth);
    chk("mw_no_ack", 32'(ack), 0);

    // Contention: all four read 0..3, requests held through five grants.
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    for (int c = 0; c < NCORE; c++) drive_core(c, 1'b1, 1'b0, 8'(c), 8'h00);
    for (int n = 0; n < 5; n++) begin
      wait_ack(12, ack, lat, nre, nwe, saddr, swd, busy_ok, nboth);
      chk($sformatf("ct%0d_ack", n),   32'(ack), 32'(exp_seq[n]));
      chk($sformatf("ct%0d_rdata", n), 32'(bus.core_rdata), 32'(exp_dat[n]));
    end
    clear_reqs();

    // Make core 3 the last grant, then cores 3 and 1 contend: 1 first, then 3.
    @(posedge Clk); #1;
    drive_core(3, 1'b1, 1'b0, 8'h03, 8'h00);
    wait_ack(12, ack, lat, nre, nwe, saddr, swd, busy_ok, nboth);
    chk("wr_pre_ack", 32'(ack), 32'b1000);
    clear_reqs();
    @(posedge Clk); #1;
    drive_core(1, 1'b1, 1'b0, 8'h01, 8'h00);
    drive_core(3, 1'b1, 1'b0, 8'h03, 8'h00);
    wait_ack(12, ack, lat, nre, nwe, saddr, swd, busy_ok, nboth);
    chk("wr_first",       32'(ack), 32'b0010);
    chk("wr_first_rdata", 32'(bus.core_rdata), 32'h22);
    drive_core(1, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_ack(12, ack, lat, nre, nwe, saddr, swd, busy_ok, nboth);
    chk("wr_second",       32'(ack), 32'b1000);
    chk("wr_second_rdata", 32'(bus.core_rdata), 32'h44);
    clear_reqs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
